md_scheduler: RTL
=================

Name: md_scheduler

Overview:
Multiply/divide sequencing unit for the 5-stage MIPS pipeline. Accepts mult/multu/div/divu from the E stage, models fixed-latency execution with a countdown, and owns the HI/LO registers. Handles mthi/mtlo writes. Generates the D-stage stall for any HI/LO-class instruction that arrives while an operation is starting or in flight.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  E-stage instr is mult/multu/div/divu (single-cycle pulse per instr)
md_op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled when start=1
rs_val  in  32  forwarded rs operand (dividend / multiplicand)
rt_val  in  32  forwarded rt operand (divisor / multiplier)
mt_we  in  1  E-stage instr is mthi/mtlo
mt_sel  in  1  0 = LO, 1 = HI
mt_data  in  32  forwarded rs value for mthi/mtlo
d_md_use  in  1  D-stage instr is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
busy  out  1  operation in flight
stall  out  1  D-stage stall request (combinational)
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset: state IDLE, counter 0, busy 0, hi 0, lo 0, pending result cleared. Reset mid-operation aborts it; no commit.
- States: IDLE, RUN.
- IDLE and start=1: compute the 64-bit result combinationally from rs_val/rt_val/md_op and latch it into pending_hi/pending_lo. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN. busy rises the next cycle.
- RUN: counter decrements each cycle. At the edge where counter==1, copy pending into hi/lo, go to IDLE, and clear busy.
- Result: busy is high for exactly N cycles after the start cycle. The new hi/lo is visible in the cycle after the last busy cycle.
- stall = d_md_use & (start | busy). This is pure combinational logic and is not registered.
- Arithmetic rules:
  - mult: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
  - multu: same as mult, unsigned.
  - div: signed; quotient truncates toward zero -> lo; remainder takes the sign of the dividend -> hi.
  - divu: unsigned quotient -> lo, remainder -> hi.
- Divide by zero (rt_val==0): full DIV_CYCLES busy period still runs; hi/lo left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no trap).
- mt_we in IDLE with start=0: the selected register is written with mt_data at the edge; the other register is unchanged.
- Protocol violations (the pipeline's stall logic guarantees these never happen):
  - start or mt_we while busy: ignored, no state change.
  - start and mt_we in the same cycle: start wins, mt ignored.
- Back-to-back: start is accepted in the first IDLE cycle after completion (zero bubble).
- hi/lo outputs are register outputs only. There is no bypass of pending values; mfhi/mflo is held off by stall.

Decomposition:
- Shared package: md_op encodings (MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11), state encoding (ST_IDLE, ST_RUN), counter width constant MD_CNT_W=4.
- One sub-module, md_compute: purely combinational; takes md_op, rs_val, rt_val; produces res_hi, res_lo and div_zero. Sign handling lives here.
- md_scheduler holds the FSM, counter, pending registers, HI/LO and stall logic.

Test Plan:
1. reset; start, mult, rs=0xFFFFFFF9 (-7), rt=3 -> busy=1 for exactly 5 cycles; the cycle after, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
2. multu rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
3. div rs=0xFFFFFFF9, rt=2 -> 10 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7, rt=0 with prior hi/lo=0x11/0x22 -> 10 busy cycles, hi/lo remain 0x11/0x22.
4. Stall: start div with d_md_use=1 in the same cycle -> stall=1 in that cycle and all 10 busy cycles; stall=0 the cycle after. With d_md_use=0, stall=0 throughout.
5. mt_we=1, mt_sel=1, mt_data=0xDEADBEEF in IDLE -> hi=0xDEADBEEF next cycle, lo unchanged. Then start mult in the very next cycle -> accepted with no bubble.
6. Start mult (rs=2, rt=3), assert reset on busy cycle 3 -> next cycle busy=0, hi=lo=0, and no late commit of 6 in the following 5 cycles.

Source files
------------

// File: rtl/md_scheduler_pkg.sv
// Shared encodings for the multiply/divide scheduler: operation codes,
// FSM states and the width of the busy countdown.
package md_scheduler_pkg;

  localparam int MD_CNT_W = 4;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage

// File: rtl/md_scheduler_if.sv
// E/D-stage pipeline signals into the mult/div unit and its HI/LO,
// busy and stall outputs back to the pipeline.
interface md_scheduler_if;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mt_we;
  logic        mt_sel;
  logic [31:0] mt_data;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, rs_val, rt_val, mt_we, mt_sel, mt_data, d_md_use,
    input  busy, stall, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, mt_we, mt_sel, mt_data, d_md_use,
    output busy, stall, hi, lo
  );
endinterface

// File: rtl/md_compute.sv
// Combinational 32x32 multiply / divide datapath producing the HI/LO pair.
// Signed division works on magnitudes and restores signs afterwards.
module md_compute
  import md_scheduler_pkg::*;
(
  input  md_op_e      md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  always_comb begin
    prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u     = {32'd0, rs_val} * {32'd0, rt_val};
    signed_div = (md_op == MD_DIV);
    rs_mag     = (signed_div && rs_val[31]) ? (32'd0 - rs_val) : rs_val;
    rt_mag     = (signed_div && rt_val[31]) ? (32'd0 - rt_val) : rt_val;
    // Divisor forced non-zero so the datapath never sees x/0; result is discarded then.
    divisor    = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    q_mag      = rs_mag / divisor;
    r_mag      = rs_mag % divisor;
    div_zero   = (md_op == MD_DIV || md_op == MD_DIVU) && (rt_val == 32'd0);
    res_hi     = 32'd0;
    res_lo     = 32'd0;
    case (md_op)
      MD_MULT:  {res_hi, res_lo} = prod_s;
      MD_MULTU: {res_hi, res_lo} = prod_u;
      MD_DIV: begin
        res_lo = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag) : q_mag;
        res_hi = rs_val[31] ? (32'd0 - r_mag) : r_mag;
      end
      MD_DIVU: begin
        res_lo = q_mag;
        res_hi = r_mag;
      end
    endcase
  end

endmodule

// File: rtl/md_scheduler.sv
// Mult/div sequencing unit: fixed-latency busy countdown, HI/LO ownership,
// mthi/mtlo writes and the D-stage stall.
//   state   | meaning
//   ST_IDLE | accepting start or mthi/mtlo
//   ST_RUN  | result pending, counting down to commit
module md_scheduler
  import md_scheduler_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset,
  md_scheduler_if.slave  md_if
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
  localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]           pend_hi_q, pend_hi_d;
  logic [31:0]           pend_lo_q, pend_lo_d;
  logic                  pend_dz_q, pend_dz_d;
  logic [31:0]           hi_q, hi_d;
  logic [31:0]           lo_q, lo_d;

  md_op_e      op_in;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  assign op_in = md_op_e'(md_if.md_op);

  md_compute u_compute (
    .md_op    (op_in),
    .rs_val   (md_if.rs_val),
    .rt_val   (md_if.rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md_if.start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_dz_d = div_zero;
          cnt_d     = (op_in == MD_DIV || op_in == MD_DIVU) ? DIV_LOAD : MULT_LOAD;
          state_d   = ST_RUN;
        end else if (md_if.mt_we) begin
          if (md_if.mt_sel) hi_d = md_if.mt_data;
          else              lo_d = md_if.mt_data;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign md_if.busy  = (state_q == ST_RUN);
  assign md_if.stall = md_if.d_md_use & (md_if.start | md_if.busy);
  assign md_if.hi    = hi_q;
  assign md_if.lo    = lo_q;

endmodule
